// File: rtl/mem_arb_pkg.sv
// Shared types for the iCache/dCache memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/arb_priority.sv
// Winner selection between iCache and dCache with an anti-starvation counter:
// dCache normally wins, but after STARVE_LIMIT dCache grants taken while the
// iCache was waiting, the iCache gets the next grant.
module arb_priority
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   resetn,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   idle,
    input  logic   grant,
    input  owner_t grant_owner,
    output owner_t winner
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_r;
    logic             starved_s;

    assign starved_s = (starve_cnt_r == CNT_MAX);

    // Pick the winner: dCache first unless the iCache has been starved.
    always_comb begin
        winner = OWN_NONE;
        if (i_req && (!d_req || starved_s)) begin
            winner = OWN_I;
        end else if (d_req) begin
            winner = OWN_D;
        end else begin
            winner = OWN_NONE;
        end
    end

    // Count dCache grants taken while iCache waits; saturate, clear on relief.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (idle && !i_req) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (grant && (grant_owner == OWN_I)) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (grant && (grant_owner == OWN_D) && i_req && !starved_s) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one word-wide memory port between iCache refills and dCache traffic.
// One outstanding transaction at a time; a requester holding its lock keeps
// the port between transactions so a line refill is never interleaved.
module cache_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_lock,
    output logic                  i_addr_ok,
    output logic                  i_data_ok,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [1:0]            d_size,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_lock,
    output logic                  d_addr_ok,
    output logic                  d_data_ok,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [1:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            owner,
    output logic                  arb_busy
);

    arb_state_t            state_r;
    owner_t                owner_r;
    logic                  busy_r;
    logic                  lat_wr_r;
    logic [1:0]            lat_size_r;
    logic [ADDR_WIDTH-1:0] lat_addr_r;
    logic [DATA_WIDTH-1:0] lat_wdata_r;

    owner_t                winner_s;
    owner_t                src_s;
    logic                  src_wr_s;
    logic [1:0]            src_size_s;
    logic [ADDR_WIDTH-1:0] src_addr_s;
    logic [DATA_WIDTH-1:0] src_wdata_s;
    logic                  own_req_s;
    logic                  own_lock_s;
    logic                  idle_s;
    logic                  grant_s;
    logic                  addr_hs_s;
    logic                  done_s;

    assign idle_s    = (state_r == IDLE);
    assign grant_s   = idle_s && (i_req || d_req);
    assign addr_hs_s = (state_r == ADDR) && mem_addr_ok;
    assign done_s    = mem_data_ok && (addr_hs_s || (state_r == DATA));

    arb_priority #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk        (clk),
        .resetn     (resetn),
        .i_req      (i_req),
        .d_req      (d_req),
        .idle       (idle_s),
        .grant      (grant_s),
        .grant_owner(winner_s),
        .winner     (winner_s)
    );

    // Request and lock of whichever cache currently owns the port.
    always_comb begin
        own_req_s  = 1'b0;
        own_lock_s = 1'b0;
        case (owner_r)
            OWN_I: begin
                own_req_s  = i_req;
                own_lock_s = i_lock;
            end
            OWN_D: begin
                own_req_s  = d_req;
                own_lock_s = d_lock;
            end
            default: begin
                own_req_s  = 1'b0;
                own_lock_s = 1'b0;
            end
        endcase
    end

    // Request fields to latch: the new winner in IDLE, else the current owner.
    always_comb begin
        src_s       = idle_s ? winner_s : owner_r;
        src_wr_s    = 1'b0;
        src_size_s  = SZ_WORD;
        src_addr_s  = {ADDR_WIDTH{1'b0}};
        src_wdata_s = {DATA_WIDTH{1'b0}};
        case (src_s)
            OWN_I: begin
                src_wr_s    = 1'b0;
                src_size_s  = SZ_WORD;
                src_addr_s  = i_addr;
                src_wdata_s = {DATA_WIDTH{1'b0}};
            end
            OWN_D: begin
                src_wr_s    = d_wr;
                src_size_s  = d_size;
                src_addr_s  = d_addr;
                src_wdata_s = d_wdata;
            end
            default: begin
                src_wr_s    = 1'b0;
                src_size_s  = SZ_WORD;
                src_addr_s  = {ADDR_WIDTH{1'b0}};
                src_wdata_s = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // Transaction FSM with request latch and registered owner/busy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= IDLE;
            owner_r     <= OWN_NONE;
            busy_r      <= 1'b0;
            lat_wr_r    <= 1'b0;
            lat_size_r  <= 2'd0;
            lat_addr_r  <= {ADDR_WIDTH{1'b0}};
            lat_wdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        state_r     <= ADDR;
                        owner_r     <= winner_s;
                        busy_r      <= 1'b1;
                        lat_wr_r    <= src_wr_s;
                        lat_size_r  <= src_size_s;
                        lat_addr_r  <= src_addr_s;
                        lat_wdata_r <= src_wdata_s;
                    end
                end
                ADDR, DATA: begin
                    if (done_s) begin
                        if (own_lock_s) begin
                            state_r <= HOLD;
                        end else begin
                            state_r <= IDLE;
                            owner_r <= OWN_NONE;
                            busy_r  <= 1'b0;
                        end
                    end else if (addr_hs_s) begin
                        state_r <= DATA;
                    end
                end
                HOLD: begin
                    if (own_req_s) begin
                        state_r     <= ADDR;
                        lat_wr_r    <= src_wr_s;
                        lat_size_r  <= src_size_s;
                        lat_addr_r  <= src_addr_s;
                        lat_wdata_r <= src_wdata_s;
                    end else if (!own_lock_s) begin
                        state_r <= IDLE;
                        owner_r <= OWN_NONE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    owner_r <= OWN_NONE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = (state_r == ADDR);
    assign mem_wr    = lat_wr_r;
    assign mem_size  = lat_size_r;
    assign mem_addr  = lat_addr_r;
    assign mem_wdata = lat_wdata_r;

    assign i_addr_ok = addr_hs_s && (owner_r == OWN_I);
    assign d_addr_ok = addr_hs_s && (owner_r == OWN_D);
    assign i_data_ok = done_s && (owner_r == OWN_I);
    assign d_data_ok = done_s && (owner_r == OWN_D);
    assign i_rdata   = i_data_ok ? mem_rdata : {DATA_WIDTH{1'b0}};
    assign d_rdata   = d_data_ok ? mem_rdata : {DATA_WIDTH{1'b0}};

    assign owner     = owner_r;
    assign arb_busy  = busy_r;

endmodule
